uart_rx: RTL and testbench

Serial receiver that consumes the line driven by the team's UART transmitter. Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
Oversamples the line on a tick of OVERSAMPLE × baud (clk_en), samples each bit at its centre, and presents the received byte with a ready/clear handshake. Parity, framing and overrun errors are flagged.
Sits between the board RX pin (or TX loopback) and the consuming logic.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and parity helper
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Encodings are shared with the transmitter so both sides decode alike.
  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_START  = 3'd1;
  localparam logic [2:0] STATE_DATA   = 3'd2;
  localparam logic [2:0] STATE_PARITY = 3'd3;
  localparam logic [2:0] STATE_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = STATE_IDLE,
    ST_START  = STATE_START,
    ST_DATA   = STATE_DATA,
    ST_PARITY = STATE_PARITY,
    ST_STOP   = STATE_STOP
  } uart_state_e;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for an asynchronous idle-high pin
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8-bit UART receiver with parity, framing and overrun flags
module uart_rx
  import uart_pkg::*;
#(
  parameter logic PARITY_TYPE = PARITY_EVEN,
  parameter int   OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        sample_cnt_q, sample_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [7:0]           dout_q, dout_d;
  logic                 rdy_q, rdy_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 wait_high_q, wait_high_d;
  logic                 done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      dout_q       <= '0;
      rdy_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
      wait_high_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      dout_q       <= dout_d;
      rdy_q        <= rdy_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
      wait_high_q  <= wait_high_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    dout_d       = dout_q;
    rdy_d        = rdy_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    ovr_d        = ovr_q;
    wait_high_d  = wait_high_q;
    done         = 1'b0;

    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          // A low stop bit must see the line go high before a new start edge counts.
          if (wait_high_q) begin
            if (rx_s) wait_high_d = 1'b0;
          end else if (!rx_s) begin
            state_d      = ST_START;
            sample_cnt_d = '0;
          end
        end
        ST_START: begin
          if (sample_cnt_q == CNT_MID) begin
            sample_cnt_d = '0;
            if (!rx_s) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (sample_cnt_q == CNT_LAST) begin
            shift_d[bit_cnt_q] = rx_s;
            sample_cnt_d       = '0;
            if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
            else                       bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (sample_cnt_q == CNT_LAST) begin
            par_d        = rx_s;
            sample_cnt_d = '0;
            state_d      = ST_STOP;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (sample_cnt_q == CNT_LAST) begin
            sample_cnt_d = '0;
            state_d      = ST_IDLE;
            wait_high_d  = ~rx_s;
            done         = 1'b1;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Completion outranks a same-cycle acknowledge.
    if (done) begin
      dout_d = shift_q;
      rdy_d  = 1'b1;
      perr_d = par_q ^ parity_of(shift_q, PARITY_TYPE);
      ferr_d = ~rx_s;
      ovr_d  = rdy_q & ~rdy_clr;
    end else if (rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign dout        = dout_q;
  assign rdy         = rdy_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx
module tb_uart_rx;

  localparam logic TB_PARITY = 1'b0;
  localparam int   BIT_CLKS  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [1:0] ph = 2'd0;
  logic       clk_en;
  logic [7:0] dout;
  logic       rdy, parity_err, frame_err, overrun_err, rx_busy;

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign clk_en = (ph == 2'd3);

  uart_rx #(.PARITY_TYPE(TB_PARITY), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .rx          (rx),
    .rdy_clr     (rdy_clr),
    .dout        (dout),
    .rdy         (rdy),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   completions = 0;
  logic model_rdy = 1'b0;

  function automatic logic good_parity(input logic [7:0] d);
    return (($countones(d) % 2) == 1) ^ TB_PARITY;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // clr_mode: 0 no ack, 1 ack shortly after mid-stop, 2 ack on the completion cycle.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int clr_mode, input int nbits);
    logic [10:0] bits;
    exp_t        e;
    bits = {stop, par, d, 1'b0};
    if (nbits == 11) begin
      e.data = d;
      e.perr = (par != good_parity(d));
      e.ferr = ~stop;
      e.ovr  = model_rdy && (clr_mode != 2);
      sb_q.push_back(e);
      model_rdy = (clr_mode != 1);
    end
    @(negedge clk);
    while (ph != 2'd0) @(negedge clk);
    for (int c = 0; c < nbits * BIT_CLKS; c++) begin
      if (c > 0) @(negedge clk);
      rx      = bits[c / BIT_CLKS];
      rdy_clr = (clr_mode == 1 && c == 683) || (clr_mode == 2 && c == 675);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_and_check();
    @(negedge clk);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr   = 1'b0;
    model_rdy = 1'b0;
    check("clr_rdy", 32'(rdy), 32'd0);
    check("clr_overrun", 32'(overrun_err), 32'd0);
  endtask

  initial begin : monitor
    int   busy_cnt;
    logic prev_busy;
    exp_t e;
    busy_cnt  = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !rx_busy && busy_cnt > 200) begin
          completions++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", dout);
          end else begin
            e = sb_q.pop_front();
            check("byte_rdy_dout_perr_ferr_ovr",
                  32'({rdy, dout, parity_err, frame_err, overrun_err}),
                  32'({1'b1, e.data, e.perr, e.ferr, e.ovr}));
          end
        end
        busy_cnt  = rx_busy ? busy_cnt + 1 : 0;
        prev_busy = rx_busy;
      end
    end
  end

  initial begin : stim
    int          c0;
    logic [7:0]  d;
    logic        par, stop;
    int          mode;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({dout, rdy, parity_err, frame_err, overrun_err, rx_busy}), 32'd0);
    rst = 1'b0;
    idle(20);

    send_frame(8'hA5, 1'b0, 1'b1, 0, 11);
    idle(40);
    clear_and_check();

    send_frame(8'h3C, 1'b1, 1'b1, 0, 11);
    idle(40);
    send_frame(8'h01, 1'b1, 1'b1, 0, 11);
    idle(40);
    clear_and_check();

    send_frame(8'h55, 1'b0, 1'b0, 0, 11);
    idle(200);
    c0 = completions;
    @(negedge clk);
    while (ph != 2'd0) @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(100);
    check("glitch_busy", 32'(rx_busy), 32'd0);
    check("glitch_rdy", 32'(rdy), 32'(model_rdy));
    check("glitch_no_byte", 32'(completions), 32'(c0));
    clear_and_check();

    send_frame(8'h11, 1'b0, 1'b1, 0, 11);
    idle(40);
    send_frame(8'h22, 1'b0, 1'b1, 0, 11);
    idle(40);
    clear_and_check();
    send_frame(8'h33, 1'b0, 1'b1, 2, 11);
    idle(40);
    check("collision_rdy", 32'(rdy), 32'd1);

    send_frame(8'hF0, 1'b0, 1'b1, 0, 5);
    #2 rst = 1'b1;
    #1;
    check("midframe_reset_outputs",
          32'({dout, rdy, parity_err, frame_err, overrun_err, rx_busy}), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    model_rdy = 1'b0;
    idle(40);
    send_frame(8'h0F, 1'b0, 1'b1, 0, 11);
    idle(40);
    clear_and_check();

    send_frame(8'h00, 1'b0, 1'b1, 1, 11);
    send_frame(8'hFF, 1'b0, 1'b1, 1, 11);
    send_frame(8'h80, 1'b1, 1'b1, 1, 11);
    idle(40);

    repeat (8) begin
      d    = 8'($urandom);
      par  = ($urandom_range(0, 3) != 0) ? good_parity(d) : ~good_parity(d);
      stop = ($urandom_range(0, 4) != 0);
      mode = $urandom_range(0, 2);
      send_frame(d, par, stop, mode, 11);
      if (!stop || $urandom_range(0, 1) == 1) idle(64 + $urandom_range(0, 200));
    end

    idle(200);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
